weight_bram_scheduler: RTL and testbench
========================================

# weight_bram_scheduler

Sequencer and arbiter for the dual-port weight BRAM feeding the MAC array. It shares BRAM port A between two users: AXI-Stream weight writes from the host, and compute-side reads driven by the weight-loading FSM strobes (address reset, +1/+2 address steps, port select). It generates both BRAM port addresses and returns `weight_from_bram_valid` and the selected weight word to the compute control path.

## Interface
- `BRAM_ADDRESS_WIDTH`, 12: BRAM address width (AW); depth is 2^AW words.
- `C_S_AXIS_TDATA_WIDTH`, 32: AXIS data width and BRAM word width (DW).

- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  reset, synchronous, active-high.
- `wr_start`  in  1  pulse; request a weight write burst starting at address 0.
- `s_axis_tdata`  in  DW  weight word.
- `s_axis_tvalid`  in  1  AXIS valid.
- `s_axis_tlast`  in  1  last beat of burst.
- `s_axis_tready`  out  1  AXIS ready.
- `weight_load_busy`  in  1  high while the compute weight FSM is not idle; requests the read session.
- `address_reset`  in  1  sets the read pointer to 0.
- `bram_control_add1`  in  1  read pointer +1.
- `bram_control_add2`  in  1  read pointer +2.
- `bram_port_sel`  in  1  output mux: 0 = port A data, 1 = port B data.
- `weight_from_bram_valid`  out  1  `weight_out` matches the current read pointer.
- `weight_out`  out  DW  selected BRAM read data.
- `bram_addr_a`, `bram_addr_b`  out  AW  BRAM port addresses.
- `bram_en_a`, `bram_en_b`, `bram_we_a`  out  1  BRAM enables / write enable.
- `bram_din_a`  out  DW  write data.
- `bram_dout_a`, `bram_dout_b`  in  DW  BRAM read data; 1-cycle registered latency.
- `wr_busy`  out  1  FSM is in WRITE.
- `write_done`  out  1  one-cycle pulse after the `tlast` beat is accepted.
- `wr_overflow`  out  1  sticky flag; a beat arrived with the address already full.

## Operation
- FSM states: IDLE, WRITE, READ. Reset puts the FSM in IDLE and clears `wr_addr`, `rd_addr`, `wr_pending`, `wr_overflow`, the valid register and `write_done`.
- `wr_start` while not in WRITE sets `wr_pending`. `wr_start` while in WRITE is ignored.
- IDLE transitions:
  - If `weight_load_busy`=1, go to READ. Read has priority when both requests are present in the same cycle.
  - Else if `wr_pending` (or `wr_start` this cycle), go to WRITE. Entering WRITE clears `wr_pending`, clears `wr_addr` and clears `wr_overflow`.
- WRITE:
  - `s_axis_tready`=1.
  - Accepted beat: `bram_we_a`=`bram_en_a`=1, `bram_addr_a`=`wr_addr`, `bram_din_a`=`tdata`, then `wr_addr`+1.
  - If `wr_addr` has reached 2^AW−1 after a write, `wr_addr` saturates. Every later beat is dropped (`we`=0), still accepted, and sets `wr_overflow`.
  - Accepted `tlast` returns the FSM to IDLE and pulses `write_done` on the next cycle.
  - WRITE is not preemptible; a `weight_load_busy` rise waits for `tlast`.
- READ:
  - `s_axis_tready`=0.
  - `bram_en_a`=`bram_en_b`=1, `bram_we_a`=0, `bram_addr_a`=`rd_addr`, `bram_addr_b`=`rd_addr`+1 (mod 2^AW).
  - `weight_load_busy`=0 returns the FSM to IDLE.
- Read pointer update, applied in every state:
  - `address_reset` has priority: `rd_addr`←0.
  - Otherwise `rd_addr`←`rd_addr` + `add1` + 2·`add2` (both asserted = +3), with modulo-2^AW wrap.
- Define chg = `address_reset` | `add1` | `add2`.
- Valid register: `valid_q` ← (state==READ) & !chg. `weight_from_bram_valid` = `valid_q` & (state==READ).
- `weight_out` = `bram_port_sel` ? `bram_dout_b` : `bram_dout_a`, combinational.
- Outside READ, `bram_addr_a` = `wr_addr` and `bram_addr_b` = `rd_addr`+1. Enables are low except during accepted write beats.

## Timing
- Reset values: all outputs 0, except that `bram_addr_b` follows its combinational definition.
- Read latency:
  - An address that is stable during cycle t produces data and valid at t+1.
  - `address_reset` at t0 gives `rd_addr`=0 at t0+1 and valid=1 at t0+2.
  - Any step strobe forces valid=0 on the next cycle; valid returns one cycle after that if no new strobe arrives.
- IDLE→READ takes one cycle after `weight_load_busy` rises. Valid cannot be high before the second READ cycle.
- Write throughput is one beat per cycle. There is no combinational path from `tvalid` to `tready`.
- `rst` during WRITE aborts the burst. Words already written stay in the BRAM; there is no pending write and `write_done` does not pulse.
- `rst` during READ drops valid on the next cycle.

## Test plan
- Write burst of 4 beats (0xA0..0xA3, `tlast` on the 4th) → addresses 0–3 written with `we`=1; `write_done` pulses 1 cycle after the last beat; `wr_busy` is low afterwards.
- Read: `weight_load_busy`=1, `address_reset` at t0, `add1` at t0+3 with sel=0 → valid high at t0+2 with data 0xA0; valid low at t0+4; valid high at t0+5 with data 0xA1.
- `add2` with `rd_addr`=2^AW−1 → `rd_addr`=1 and `bram_addr_b`=2; `add1`+`add2` together from 0 → `rd_addr`=3; `address_reset` together with `add2` → `rd_addr`=0.
- `wr_start` together with `weight_load_busy` in IDLE → FSM enters READ and `tready` stays 0. After busy falls → WRITE; `tready`=1 within 2 cycles.
- Burst of 2^AW+2 beats → last 2 beats dropped (`we`=0), `wr_overflow`=1, and the flag stays 1 until the next entry into WRITE.
- `rst` asserted mid-burst and in READ → next cycle: all outputs 0, FSM IDLE, pending write cleared.

Source files
------------

// File: rtl/weight_bram_scheduler.sv
// Weight BRAM scheduler: shares BRAM port A between AXIS weight writes and
// compute-side reads, and tracks the read pointer driven by the loader FSM.
module weight_bram_scheduler #(
  parameter int BRAM_ADDRESS_WIDTH   = 12,
  parameter int C_S_AXIS_TDATA_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wr_start,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tlast,
  output logic                            s_axis_tready,
  input  logic                            weight_load_busy,
  input  logic                            address_reset,
  input  logic                            bram_control_add1,
  input  logic                            bram_control_add2,
  input  logic                            bram_port_sel,
  output logic                            weight_from_bram_valid,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0] weight_out,
  output logic [BRAM_ADDRESS_WIDTH-1:0]   bram_addr_a,
  output logic [BRAM_ADDRESS_WIDTH-1:0]   bram_addr_b,
  output logic                            bram_en_a,
  output logic                            bram_en_b,
  output logic                            bram_we_a,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0] bram_din_a,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0] bram_dout_a,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0] bram_dout_b,
  output logic                            wr_busy,
  output logic                            write_done,
  output logic                            wr_overflow
);
  localparam int AW = BRAM_ADDRESS_WIDTH;
  localparam int DW = C_S_AXIS_TDATA_WIDTH;
  localparam logic [AW-1:0] ADDR_MAX = {AW{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_t;

  state_t        state_r;
  logic [AW-1:0] wr_addr_r;
  logic [AW-1:0] rd_addr_r;
  logic [AW-1:0] rd_next_s;
  logic [AW-1:0] rd_step_s;
  logic          wr_pending_r;
  logic          wr_full_r;
  logic          wr_overflow_r;
  logic          valid_q_r;
  logic          write_done_r;
  logic          in_write_s;
  logic          in_read_s;
  logic          accept_s;
  logic          write_s;
  logic          chg_s;

  // State decode, beat acceptance and next read pointer.
  always_comb begin
    in_write_s = (state_r == ST_WRITE);
    in_read_s  = (state_r == ST_READ);
    accept_s   = in_write_s & s_axis_tvalid;
    write_s    = accept_s & ~wr_full_r;
    chg_s      = address_reset | bram_control_add1 | bram_control_add2;
    // {add2, add1} is add1 + 2*add2, so both strobes together step by 3
    rd_step_s  = {{(AW-2){1'b0}}, bram_control_add2, bram_control_add1};
    if (address_reset) begin
      rd_next_s = {AW{1'b0}};
    end else begin
      rd_next_s = rd_addr_r + rd_step_s;
    end
  end

  // BRAM port drive, status outputs and result mux.
  always_comb begin
    s_axis_tready          = in_write_s;
    wr_busy                = in_write_s;
    bram_we_a              = write_s;
    bram_en_a              = accept_s | in_read_s;
    bram_en_b              = in_read_s;
    bram_din_a             = write_s ? s_axis_tdata : {DW{1'b0}};
    bram_addr_a            = in_read_s ? rd_addr_r : wr_addr_r;
    bram_addr_b            = rd_addr_r + {{(AW-1){1'b0}}, 1'b1};
    weight_out             = bram_port_sel ? bram_dout_b : bram_dout_a;
    weight_from_bram_valid = valid_q_r & in_read_s;
    write_done             = write_done_r;
    wr_overflow            = wr_overflow_r;
  end

  // Arbitration FSM, write pointer, read pointer and valid tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      wr_addr_r     <= {AW{1'b0}};
      rd_addr_r     <= {AW{1'b0}};
      wr_pending_r  <= 1'b0;
      wr_full_r     <= 1'b0;
      wr_overflow_r <= 1'b0;
      valid_q_r     <= 1'b0;
      write_done_r  <= 1'b0;
    end else begin
      rd_addr_r    <= rd_next_s;
      valid_q_r    <= in_read_s & ~chg_s;
      write_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (weight_load_busy) begin
            state_r <= ST_READ;
            if (wr_start) begin
              wr_pending_r <= 1'b1;
            end
          end else if (wr_pending_r | wr_start) begin
            state_r       <= ST_WRITE;
            wr_pending_r  <= 1'b0;
            wr_addr_r     <= {AW{1'b0}};
            wr_full_r     <= 1'b0;
            wr_overflow_r <= 1'b0;
          end
        end
        ST_WRITE: begin
          if (accept_s) begin
            // The top address is written once; later beats are swallowed
            if (wr_full_r) begin
              wr_overflow_r <= 1'b1;
            end else if (wr_addr_r == ADDR_MAX) begin
              wr_full_r <= 1'b1;
            end else begin
              wr_addr_r <= wr_addr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (s_axis_tlast) begin
              state_r      <= ST_IDLE;
              write_done_r <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (wr_start) begin
            wr_pending_r <= 1'b1;
          end
          if (!weight_load_busy) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_weight_bram_scheduler.sv
// Scoreboard bench for weight_bram_scheduler: a behavioural BRAM plus a
// reference memory/pointer model predict writes, read data and done pulses.
module tb_weight_bram_scheduler;
  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  typedef struct {
    int            cyc;
    int            addr;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_start = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  logic          weight_load_busy = 1'b0;
  logic          address_reset = 1'b0;
  logic          bram_control_add1 = 1'b0;
  logic          bram_control_add2 = 1'b0;
  logic          bram_port_sel = 1'b0;
  logic          weight_from_bram_valid;
  logic [DW-1:0] weight_out;
  logic [AW-1:0] bram_addr_a;
  logic [AW-1:0] bram_addr_b;
  logic          bram_en_a;
  logic          bram_en_b;
  logic          bram_we_a;
  logic [DW-1:0] bram_din_a;
  logic [DW-1:0] bram_dout_a;
  logic [DW-1:0] bram_dout_b;
  logic          wr_busy;
  logic          write_done;
  logic          wr_overflow;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int mptr   = 0;

  bit [DW-1:0] bram    [DEPTH];
  bit [DW-1:0] ref_mem [DEPTH];
  exp_t wr_q[$];
  exp_t rd_q[$];
  int   done_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  weight_bram_scheduler #(
    .BRAM_ADDRESS_WIDTH(AW),
    .C_S_AXIS_TDATA_WIDTH(DW)
  ) dut (
    .clk(clk), .rst(rst), .wr_start(wr_start),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .weight_load_busy(weight_load_busy), .address_reset(address_reset),
    .bram_control_add1(bram_control_add1), .bram_control_add2(bram_control_add2),
    .bram_port_sel(bram_port_sel), .weight_from_bram_valid(weight_from_bram_valid),
    .weight_out(weight_out), .bram_addr_a(bram_addr_a), .bram_addr_b(bram_addr_b),
    .bram_en_a(bram_en_a), .bram_en_b(bram_en_b), .bram_we_a(bram_we_a),
    .bram_din_a(bram_din_a), .bram_dout_a(bram_dout_a), .bram_dout_b(bram_dout_b),
    .wr_busy(wr_busy), .write_done(write_done), .wr_overflow(wr_overflow)
  );

  // Dual-port BRAM with one cycle of registered read latency
  always @(posedge clk) begin
    if (bram_en_a) begin
      if (bram_we_a) bram[bram_addr_a] <= bram_din_a;
      bram_dout_a <= bram[bram_addr_a];
    end
    if (bram_en_b) bram_dout_b <= bram[bram_addr_b];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s actual=%0h required=none", name, act);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write, read or done
  always @(negedge clk) begin
    exp_t e;
    if (bram_we_a === 1'b1) begin
      if (wr_q.size() == 0) unexpected("bram_write", 64'(bram_addr_a));
      else begin
        e = wr_q.pop_front();
        check("wr_cycle", 64'(cyc), 64'(e.cyc));
        check("wr_addr", 64'(bram_addr_a), 64'(e.addr));
        check("wr_data", 64'(bram_din_a), 64'(e.data));
      end
    end
    if (weight_from_bram_valid === 1'b1) begin
      if (rd_q.size() == 0) unexpected("rd_valid", 64'(weight_out));
      else begin
        e = rd_q.pop_front();
        check("rd_cycle", 64'(cyc), 64'(e.cyc));
        check("rd_data", 64'(weight_out), 64'(e.data));
      end
    end
    if (write_done === 1'b1) begin
      if (done_q.size() == 0) unexpected("write_done", 64'(cyc));
      else check("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
    end
  end

  task automatic check_idle(input string tag);
    check({tag, "_tready"}, 64'(s_axis_tready), 64'(0));
    check({tag, "_wr_busy"}, 64'(wr_busy), 64'(0));
    check({tag, "_write_done"}, 64'(write_done), 64'(0));
    check({tag, "_valid"}, 64'(weight_from_bram_valid), 64'(0));
    check({tag, "_we_a"}, 64'(bram_we_a), 64'(0));
    check({tag, "_en_a"}, 64'(bram_en_a), 64'(0));
    check({tag, "_en_b"}, 64'(bram_en_b), 64'(0));
    check({tag, "_addr_a"}, 64'(bram_addr_a), 64'(0));
    check({tag, "_addr_b"}, 64'(bram_addr_b), 64'(1));
    check({tag, "_din_a"}, 64'(bram_din_a), 64'(0));
    check({tag, "_overflow"}, 64'(wr_overflow), 64'(0));
  endtask

  // Burst of n beats with random gaps; beats past the last address are dropped
  task automatic write_burst(input int n, input bit fixed, input bit poke, input bit pulse);
    exp_t e;
    int i;
    bit poked;
    logic [DW-1:0] d;
    wr_start = pulse;
    tick();
    wr_start = 1'b0;
    check("wr_entry_tready", 64'(s_axis_tready), 64'(1));
    check("wr_entry_overflow", 64'(wr_overflow), 64'(0));
    i = 0;
    poked = 1'b0;
    while (i < n) begin
      s_axis_tvalid = ($urandom_range(0, 3) != 0);
      wr_start = 1'b0;
      if (poke && !poked && i >= n / 2) begin
        wr_start = 1'b1;
        poked = 1'b1;
      end
      if (s_axis_tvalid) begin
        d = fixed ? DW'(32'hA0 + i) : DW'($urandom);
        s_axis_tdata = d;
        s_axis_tlast = (i == n - 1);
        if (i < DEPTH) begin
          e.cyc = cyc; e.addr = i; e.data = d;
          wr_q.push_back(e);
          ref_mem[i] = d;
        end
        if (i == n - 1) done_q.push_back(cyc + 1);
        i++;
      end else begin
        s_axis_tdata = DW'($urandom);
        s_axis_tlast = 1'($urandom_range(0, 1));
      end
      tick();
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    wr_start = 1'b0;
    check("wr_busy_after", 64'(wr_busy), 64'(0));
    check("wr_overflow_after", 64'(wr_overflow), 64'(n > DEPTH));
    tick();
    check("wr_busy_settled", 64'(wr_busy), 64'(0));
  endtask

  // Read session: busy high for ncyc cycles; mode 0 random, 1 latency pattern, 2 wrap pattern
  task automatic read_session(input int ncyc, input int mode, input bit with_wr);
    bit in_rd, prev_rd, prev_chg, ar, a1, a2, sel;
    int prev_ptr;
    exp_t e;
    in_rd = 1'b0; prev_rd = 1'b0; prev_chg = 1'b1; prev_ptr = 0;
    for (int k = 0; k <= ncyc; k++) begin
      case (mode)
        1: begin
          ar = (k == 1); a1 = (k == 4); a2 = 1'b0; sel = 1'b0;
        end
        2: begin
          ar  = (k == 1) || (k == 1370) || (k == 1374);
          a1  = (k >= 2 && k <= 1366) || (k == 1372);
          a2  = (k >= 2 && k <= 1366) || (k == 1368) || (k == 1372) || (k == 1374);
          sel = 1'($urandom_range(0, 1));
        end
        default: begin
          ar  = ($urandom_range(0, 7) == 0);
          a1  = ($urandom_range(0, 3) == 0);
          a2  = ($urandom_range(0, 3) == 0);
          sel = 1'($urandom_range(0, 1));
        end
      endcase
      weight_load_busy = (k < ncyc);
      wr_start = with_wr && (k == 0);
      address_reset = ar;
      bram_control_add1 = a1;
      bram_control_add2 = a2;
      bram_port_sel = sel;
      if (in_rd) begin
        check("rd_addr_a", 64'(bram_addr_a), 64'(mptr));
        check("rd_addr_b", 64'(bram_addr_b), 64'((mptr + 1) % DEPTH));
        check("rd_tready", 64'(s_axis_tready), 64'(0));
      end
      if (in_rd && prev_rd && !prev_chg) begin
        e.cyc = cyc; e.addr = 0; e.data = ref_mem[(prev_ptr + int'(sel)) % DEPTH];
        rd_q.push_back(e);
      end
      prev_rd = in_rd;
      prev_chg = ar | a1 | a2;
      prev_ptr = mptr;
      mptr = ar ? 0 : (mptr + int'(a1) + 2 * int'(a2)) % DEPTH;
      in_rd = weight_load_busy;
      tick();
    end
    wr_start = 1'b0;
    address_reset = 1'b0;
    bram_control_add1 = 1'b0;
    bram_control_add2 = 1'b0;
    weight_load_busy = 1'b0;
  endtask

  initial begin
    exp_t e;
    logic [DW-1:0] d;
    repeat (3) tick();
    check_idle("reset");
    rst = 1'b0;

    write_burst(4, 1'b1, 1'b0, 1'b1);
    read_session(8, 1, 1'b0);
    read_session(1378, 2, 1'b0);
    write_burst(40, 1'b0, 1'b1, 1'b1);
    read_session(200, 0, 1'b0);

    // Write request collides with busy: read first, write once busy drops
    read_session(60, 0, 1'b1);
    write_burst(12, 1'b0, 1'b0, 1'b0);

    write_burst(DEPTH + 2, 1'b0, 1'b0, 1'b1);
    read_session(100, 0, 1'b0);
    check("overflow_sticky", 64'(wr_overflow), 64'(1));
    write_burst(6, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of a burst
    wr_start = 1'b1;
    tick();
    wr_start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      d = DW'($urandom);
      s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tlast = 1'b0;
      e.cyc = cyc; e.addr = b; e.data = d;
      wr_q.push_back(e);
      ref_mem[b] = d;
      tick();
    end
    s_axis_tvalid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mptr = 0;
    check_idle("rst_wr");
    tick();
    tick();
    check("rst_wr_no_pending", 64'(wr_busy), 64'(0));

    // Reset during READ with a write pending and valid high
    weight_load_busy = 1'b1; wr_start = 1'b1; address_reset = 1'b1; bram_port_sel = 1'b0;
    tick();
    wr_start = 1'b0; address_reset = 1'b0;
    tick();
    e.cyc = cyc; e.addr = 0; e.data = ref_mem[0];
    rd_q.push_back(e);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    weight_load_busy = 1'b0;
    mptr = 0;
    check_idle("rst_rd");
    tick();
    tick();
    check("rst_rd_no_pending", 64'(wr_busy), 64'(0));

    read_session(100, 0, 1'b0);
    repeat (3) tick();
    check("wr_q_drained", 64'(wr_q.size()), 64'(0));
    check("rd_q_drained", 64'(rd_q.size()), 64'(0));
    check("done_q_drained", 64'(done_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
